// File: rtl/multi_pipe_painter_pkg.sv
// Shared types and constants for the multi-pipe painter.
// Contents: FSM state enum, pixel coordinate widths, colour constants.
package painter_pkg;

    localparam int X_W = 8;   // pixel column width
    localparam int Y_W = 7;   // pixel row width

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_PIPE,
        S_DRAW_PIPE,
        S_NEXT_PIPE,
        S_ERASE_BOX,
        S_DRAW_BOX,
        S_DONE
    } state_t;

endpackage

// File: rtl/multi_pipe_painter_if.sv
// Bundle between game-state logic, the painter and the VGA adapter.
//   game side : game_pulse, pipe_x (8 bits per pipe), pipe_gap_y (7 bits per
//               pipe), box_y  ->  busy, frame_done, overrun
//   VGA side  : plot, x, y, colour
// Modports: master = game/VGA environment, slave = painter.
interface multi_pipe_painter_if #(
    parameter int NUM_PIPES = 2
);
    logic                                    game_pulse;
    logic [NUM_PIPES*painter_pkg::X_W-1:0]   pipe_x;
    logic [NUM_PIPES*painter_pkg::Y_W-1:0]   pipe_gap_y;
    logic [painter_pkg::Y_W-1:0]             box_y;
    logic                                    plot;
    logic [painter_pkg::X_W-1:0]             x;
    logic [painter_pkg::Y_W-1:0]             y;
    logic [2:0]                              colour;
    logic                                    busy;
    logic                                    frame_done;
    logic                                    overrun;

    modport master (
        output game_pulse, pipe_x, pipe_gap_y, box_y,
        input  plot, x, y, colour, busy, frame_done, overrun
    );

    modport slave (
        input  game_pulse, pipe_x, pipe_gap_y, box_y,
        output plot, x, y, colour, busy, frame_done, overrun
    );
endinterface

// File: rtl/multi_pipe_painter_column_sweeper.sv
// column_sweeper: walks one pipe column top to bottom, one row per cycle,
// and describes the pixel for the current row combinationally.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   step           advance one row this cycle (row held at 0 otherwise)
//   erase          1 = erase sweep (all rows black), 0 = draw sweep
//   x, gap_y       column and gap top row of this pipe
//   plot,y,colour  pixel for the current row
//   last           current row is the final row of the column
// Build option PAINTER_GAP_EN: draw sweeps paint gap rows black instead of
// skipping them.
module column_sweeper
    import painter_pkg::*;
#(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         GAP_H       = 32,
    parameter logic [2:0] PIPE_COLOUR = GREEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           step,
    input  logic           erase,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] gap_y,
    output logic           plot,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           last
);
    localparam int RW = Y_W + 1;
    localparam int XW = X_W + 1;

    logic [Y_W-1:0] row;
    logic [RW-1:0]  gap_end;
    logic           on_screen;
    logic           in_gap;

    // The counter self-wraps after the last row so back-to-back sweeps
    // (erase then draw) need no idle cycle between them.
    always_ff @(posedge clk) begin
        if (reset || !step || last)
            row <= '0;
        else
            row <= row + 1'b1;
    end

    // Gap end is one bit wider than a row so a gap near the bottom never
    // wraps round to the top of the screen.
    assign gap_end   = {1'b0, gap_y} + RW'(GAP_H - 1);
    assign in_gap    = ({1'b0, row} >= {1'b0, gap_y}) && ({1'b0, row} <= gap_end);
    assign on_screen = {1'b0, x} < XW'(SCREEN_W);
    assign last      = row == Y_W'(SCREEN_H - 1);
    assign y         = row;

    always_comb begin
        plot   = step && on_screen;
        colour = erase ? BLACK : PIPE_COLOUR;
        if (!erase && in_gap) begin
`ifdef PAINTER_GAP_EN
            colour = BLACK;
`else
            plot   = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/multi_pipe_painter.sv
// multi_pipe_painter: on each game_pulse erases and redraws NUM_PIPES pipe
// columns (each with a gap) and then the bird box, one pixel per cycle.
// Ports:
//   CLOCK_50  system clock
//   reset     synchronous active-high reset; aborts a frame immediately
//   bus       multi_pipe_painter_if.slave (game inputs, VGA pixel stream,
//             busy / frame_done / overrun status)
// All outputs are registered; a pixel decided in a cycle appears on the bus
// after that cycle's clock edge.
// Build option PAINTER_GAP_EN: gap rows are plotted black during the draw
// sweep (clears the bird trail); otherwise they are skipped. Timing is the
// same either way.
module multi_pipe_painter
    import painter_pkg::*;
#(
    parameter int         NUM_PIPES   = 2,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         GAP_H       = 32,
    parameter int         BOX_SIZE    = 3,
    parameter int         BOX_X       = 4,
    parameter logic [2:0] PIPE_COLOUR = GREEN,
    parameter logic [2:0] BOX_COLOUR  = YELLOW
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    multi_pipe_painter_if.slave  bus
);
    localparam int P_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    state_t                              state;
    logic [NUM_PIPES-1:0][X_W-1:0]       cur_x, prev_x;
    logic [NUM_PIPES-1:0][Y_W-1:0]       cur_gap;
    logic [Y_W-1:0]                      cur_box, prev_box;
    logic                                prev_valid;
    logic [P_W-1:0]                      p;
    logic [X_W-1:0]                      bc, br;   // box column / row

    logic           sw_step, sw_erase, sw_plot, sw_last;
    logic [X_W-1:0] sw_x;
    logic [Y_W-1:0] sw_y;
    logic [2:0]     sw_colour;

    logic           box_erase, box_vis, box_last;
    logic [Y_W-1:0] box_top;
    logic [X_W-1:0] box_row;

    assign sw_step  = (state == S_ERASE_PIPE) || (state == S_DRAW_PIPE);
    assign sw_erase = (state == S_ERASE_PIPE);
    assign sw_x     = sw_erase ? prev_x[p] : cur_x[p];

    column_sweeper #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .GAP_H      (GAP_H),
        .PIPE_COLOUR(PIPE_COLOUR)
    ) u_sweep (
        .clk   (CLOCK_50),
        .reset (reset),
        .step  (sw_step),
        .erase (sw_erase),
        .x     (sw_x),
        .gap_y (cur_gap[p]),
        .plot  (sw_plot),
        .y     (sw_y),
        .colour(sw_colour),
        .last  (sw_last)
    );

    // Box rows are formed 8 bits wide and clipped before dropping to 7 bits,
    // so a box hanging off the bottom never wraps to the top rows.
    assign box_erase = (state == S_ERASE_BOX);
    assign box_top   = box_erase ? prev_box : cur_box;
    assign box_row   = X_W'(box_top) + br;
    assign box_vis   = box_row < X_W'(SCREEN_H);
    assign box_last  = (bc == X_W'(BOX_SIZE - 1)) && (br == X_W'(BOX_SIZE - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= S_IDLE;
            bus.plot       <= 1'b0;
            bus.x          <= '0;
            bus.y          <= '0;
            bus.colour     <= BLACK;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
            prev_valid     <= 1'b0;
            p              <= '0;
            bc             <= '0;
            br             <= '0;
            cur_x          <= '0;
            prev_x         <= '0;
            cur_gap        <= '0;
            cur_box        <= '0;
            prev_box       <= '0;
        end else begin
            bus.plot       <= 1'b0;
            bus.frame_done <= 1'b0;
            // Any pulse outside IDLE (DONE included) is dropped and flagged.
            if (bus.game_pulse && state != S_IDLE)
                bus.overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.game_pulse) begin
                        cur_x    <= bus.pipe_x;
                        cur_gap  <= bus.pipe_gap_y;
                        cur_box  <= bus.box_y;
                        p        <= '0;
                        bus.busy <= 1'b1;
                        state    <= prev_valid ? S_ERASE_PIPE : S_DRAW_PIPE;
                    end
                end

                S_ERASE_PIPE, S_DRAW_PIPE: begin
                    bus.plot   <= sw_plot;
                    bus.x      <= sw_x;
                    bus.y      <= sw_y;
                    bus.colour <= sw_colour;
                    if (sw_last)
                        state <= sw_erase ? S_DRAW_PIPE : S_NEXT_PIPE;
                end

                S_NEXT_PIPE: begin
                    if (p == P_W'(NUM_PIPES - 1)) begin
                        bc    <= '0;
                        br    <= '0;
                        state <= prev_valid ? S_ERASE_BOX : S_DRAW_BOX;
                    end else begin
                        p     <= p + 1'b1;
                        state <= prev_valid ? S_ERASE_PIPE : S_DRAW_PIPE;
                    end
                end

                S_ERASE_BOX, S_DRAW_BOX: begin
                    bus.plot   <= box_vis;
                    bus.x      <= X_W'(BOX_X) + bc;
                    bus.y      <= box_row[Y_W-1:0];
                    bus.colour <= box_erase ? BLACK : BOX_COLOUR;
                    if (bc == X_W'(BOX_SIZE - 1)) begin
                        bc <= '0;
                        br <= box_last ? '0 : br + 1'b1;
                    end else begin
                        bc <= bc + 1'b1;
                    end
                    if (box_last)
                        state <= box_erase ? S_DRAW_BOX : S_DONE;
                end

                S_DONE: begin
                    bus.frame_done <= 1'b1;
                    bus.busy       <= 1'b0;
                    prev_x         <= cur_x;
                    prev_box       <= cur_box;
                    prev_valid     <= 1'b1;
                    state          <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_pipe_painter.sv
// Directed bench for multi_pipe_painter: a table of frames with hand-computed
// pixel statistics plus hand-written overrun / mid-frame reset sequences.
// Frame length is the number of clock edges after the accepting edge up to
// and including the edge that raises frame_done.
module tb_multi_pipe_painter;
    import painter_pkg::*;

`ifdef PAINTER_GAP_EN
    localparam int GP = 1;
`else
    localparam int GP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_pipe_painter_if #(.NUM_PIPES(2)) bus ();
    multi_pipe_painter #(.NUM_PIPES(2)) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] px;
        logic [13:0] gy;
        logic [6:0]  by;
        int          chk_x;
        int          len;
        int          n_plot;
        int          n_green;
        int          n_black;
        int          n_yellow;
        int          n_black_chk;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_pass   = 0;

    // running pixel totals kept by the monitor
    int t_plot = 0, t_green = 0, t_black = 0, t_yellow = 0;
    int t_x200 = 0, t_oob = 0, t_bchk = 0, t_ggap = 0;
    int mon_chk_x = -1;
    int mon_px[2];
    int mon_g[2];

    // per-frame results
    int f_len, f_plot, f_green, f_black, f_yellow, f_x200, f_oob, f_bchk, f_ggap;

    always @(negedge clk) begin
        if (bus.plot === 1'b1) begin
            t_plot++;
            if (bus.colour == 3'b010) t_green++;
            if (bus.colour == 3'b000) t_black++;
            if (bus.colour == 3'b110) t_yellow++;
            if (bus.x == 8'd200) t_x200++;
            if (bus.x >= 8'd160 || bus.y >= 7'd120) t_oob++;
            if (bus.colour == 3'b000 && int'(bus.x) == mon_chk_x) t_bchk++;
            for (int i = 0; i < 2; i++)
                if (bus.colour == 3'b010 && int'(bus.x) == mon_px[i] &&
                    int'(bus.y) >= mon_g[i] && int'(bus.y) <= mon_g[i] + 31)
                    t_ggap++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives one frame request and waits (bounded) for frame_done. A second
    // game_pulse is raised on edge pulse_at (0 = none).
    task automatic run_frame(input logic [15:0] px, input logic [13:0] gy,
                             input logic [6:0] by, input int cx, input int pulse_at);
        int b_plot, b_green, b_black, b_yellow, b_x200, b_oob, b_bchk, b_ggap;
        @(negedge clk);
        mon_chk_x = cx;
        mon_px[0] = int'(px[7:0]);
        mon_px[1] = int'(px[15:8]);
        mon_g[0]  = int'(gy[6:0]);
        mon_g[1]  = int'(gy[13:7]);
        b_plot = t_plot; b_green = t_green; b_black = t_black; b_yellow = t_yellow;
        b_x200 = t_x200; b_oob = t_oob; b_bchk = t_bchk; b_ggap = t_ggap;
        bus.pipe_x     = px;
        bus.pipe_gap_y = gy;
        bus.box_y      = by;
        bus.game_pulse = 1'b1;
        @(negedge clk);
        bus.game_pulse = 1'b0;
        f_len = 0;
        while (bus.frame_done !== 1'b1 && f_len < 2000) begin
            bus.game_pulse = (f_len + 1 == pulse_at);
            @(negedge clk);
            f_len++;
        end
        bus.game_pulse = 1'b0;
        f_plot = t_plot - b_plot;     f_green = t_green - b_green;
        f_black = t_black - b_black;  f_yellow = t_yellow - b_yellow;
        f_x200 = t_x200 - b_x200;     f_oob = t_oob - b_oob;
        f_bchk = t_bchk - b_bchk;     f_ggap = t_ggap - b_ggap;
    endtask

    initial begin
        int idle_plots;

        // px = {pipe1, pipe0}, gy = {gap1, gap0}
        vecs[0] = '{16'h6428, {7'd50, 7'd20},  7'd60,  40, 252,
                    185 + 64*GP, 176, 64*GP,        9, 32*GP};
        vecs[1] = '{16'h6327, {7'd50, 7'd20},  7'd60,  40, 501,
                    434 + 64*GP, 176, 249 + 64*GP,  9, 120};
        vecs[2] = '{16'hC827, {7'd50, 7'd20},  7'd60,  99, 501,
                    346 + 32*GP, 88,  249 + 32*GP,  9, 120};
        vecs[3] = '{16'hC827, {7'd50, 7'd20},  7'd118, 39, 501,
                    223 + 32*GP, 88,  129 + 32*GP,  6, 120 + 32*GP};
        vecs[4] = '{16'h6428, {7'd100, 7'd20}, 7'd10,  39, 501,
                    323 + 52*GP, 188, 126 + 52*GP,  9, 120};

        bus.game_pulse = 1'b0;
        bus.pipe_x     = '0;
        bus.pipe_gap_y = '0;
        bus.box_y      = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_plot",    int'(bus.plot), 0);
        chk("rst_xy",      int'({bus.x, bus.y, bus.colour}), 0);
        chk("rst_busy",    int'(bus.busy), 0);
        chk("rst_done",    int'(bus.frame_done), 0);
        chk("rst_overrun", int'(bus.overrun), 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].px, vecs[i].gy, vecs[i].by, vecs[i].chk_x, 0);
            chk($sformatf("v%0d_len", i),       f_len,    vecs[i].len);
            chk($sformatf("v%0d_plots", i),     f_plot,   vecs[i].n_plot);
            chk($sformatf("v%0d_green", i),     f_green,  vecs[i].n_green);
            chk($sformatf("v%0d_black", i),     f_black,  vecs[i].n_black);
            chk($sformatf("v%0d_yellow", i),    f_yellow, vecs[i].n_yellow);
            chk($sformatf("v%0d_black_at_x", i), f_bchk,  vecs[i].n_black_chk);
            chk($sformatf("v%0d_x200", i),      f_x200,   0);
            chk($sformatf("v%0d_offscreen", i), f_oob,    0);
            chk($sformatf("v%0d_green_gap", i), f_ggap,   0);
            @(negedge clk);
            chk($sformatf("v%0d_done_1cyc", i), int'(bus.frame_done), 0);
            chk($sformatf("v%0d_busy_idle", i), int'(bus.busy), 0);
        end
        chk("ovr_before", int'(bus.overrun), 0);

        // game_pulse on edge 130 lands in the pipe0 draw sweep
        run_frame(16'h6428, {7'd50, 7'd20}, 7'd60, 40, 130);
        chk("ovr_len",   f_len,   501);
        chk("ovr_black", f_black, 249 + 64*GP);
        chk("ovr_green", f_green, 176);
        chk("ovr_set",   int'(bus.overrun), 1);
        repeat (5) @(negedge clk);
        chk("ovr_held",  int'(bus.overrun), 1);
        chk("ovr_no_new_frame", int'(bus.busy), 0);

        // reset during the pipe0 erase sweep
        @(negedge clk);
        bus.game_pulse = 1'b1;
        @(negedge clk);
        bus.game_pulse = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy",  int'(bus.busy), 1);
        chk("mid_plot",  int'(bus.plot), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_plot",    int'(bus.plot), 0);
        chk("abort_busy",    int'(bus.busy), 0);
        chk("abort_overrun", int'(bus.overrun), 0);
        idle_plots = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.plot !== 1'b0) idle_plots++;
        end
        chk("abort_quiet", idle_plots, 0);
        run_frame(16'h6428, {7'd50, 7'd20}, 7'd60, 40, 0);
        chk("post_rst_len",   f_len,   252);
        chk("post_rst_black", f_black, 64*GP);
        chk("post_rst_green", f_green, 176);

        // game_pulse on the DONE edge is an overrun, not a new frame
        run_frame(16'h6428, {7'd50, 7'd20}, 7'd60, 40, 501);
        chk("done_ovr_len", f_len, 501);
        chk("done_ovr_set", int'(bus.overrun), 1);
        @(negedge clk);
        chk("done_ovr_busy", int'(bus.busy), 0);
        chk("done_ovr_plot", int'(bus.plot), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
